// File: rtl/uart_host_pkg.sv
// Shared types and register map for the UART host sequencer and its bus engine.
package uart_host_pkg;

  typedef enum logic [3:0] {
    StInitStop,
    StInitBaud,
    StInitRun,
    StInitMask,
    StIdle,
    StRdStat,
    StRdData,
    StGrant,
    StWrData,
    StWrGo,
    StWrRun
  } seq_state_t;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_INT    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  // Status bit positions; RUN/GO on write, RUN/RXRDY/TXFULL/TXBUSY on read.
  localparam int unsigned ST_RUN    = 0;
  localparam int unsigned ST_GO     = 1;
  localparam int unsigned ST_RXRDY  = 1;
  localparam int unsigned ST_TXFULL = 2;
  localparam int unsigned ST_TXBUSY = 3;

endpackage

// File: rtl/uart_host_sequencer_if.sv
// UART peripheral CPU-port signals; master = sequencer side, slave = UART side.
interface uart_host_sequencer_if;
  logic [1:0] ADDR;
  logic       NCS;
  logic       NO;
  logic       NW;
  logic [7:0] DATA_OUT;
  logic       DATA_OE;
  logic [7:0] DATA_IN;
  logic       NINT;

  modport master (
    output ADDR, NCS, NO, NW, DATA_OUT, DATA_OE,
    input  DATA_IN, NINT
  );

  modport slave (
    input  ADDR, NCS, NO, NW, DATA_OUT, DATA_OE,
    output DATA_IN, NINT
  );
endinterface

// File: rtl/uart_bus_master.sv
// Two-cycle UART register access engine: one strobe cycle, then one all-high turnaround.
module uart_bus_master (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  uart_host_sequencer_if.master bus
);

  logic       turn_q;
  logic [7:0] rdata_q;
  logic       access;

  // start is held for the whole op; turn_q toggles access -> turnaround -> next access.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      turn_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else if (start) begin
      turn_q <= ~turn_q;
      if (!turn_q && !wr) begin
        rdata_q <= bus.DATA_IN;
      end
    end else begin
      turn_q <= 1'b0;
    end
  end

  always_comb begin
    access       = start & ~turn_q;
    bus.ADDR     = access ? addr : 2'd0;
    bus.NCS      = ~access;
    bus.NW       = ~(access & wr);
    bus.NO       = ~(access & ~wr);
    bus.DATA_OE  = access & wr;
    bus.DATA_OUT = (access & wr) ? wdata : 8'h00;
    done         = start & turn_q;
    rdata        = rdata_q;
  end

endmodule

// File: rtl/uart_host_sequencer.sv
// UART host sequencer: init sequence, round-robin TX arbitration with GO bursts, RX draining.
module uart_host_sequencer
  import uart_host_pkg::*;
#(
  parameter logic [7:0]  BAUD_DIV      = 8'h0C,
  parameter logic [7:0]  INT_MASK      = 8'h02,
  parameter int unsigned BURST_MAX     = 16,
  parameter int unsigned POLL_INTERVAL = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  uart_host_sequencer_if.master bus
);

  localparam int unsigned CntW  = $clog2(BURST_MAX + 1);
  localparam int unsigned PollW = $clog2(POLL_INTERVAL + 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(BURST_MAX);
  localparam logic [PollW-1:0] PollLoad = PollW'(POLL_INTERVAL);
  localparam logic [7:0] StRunOnly = 8'b1 << ST_RUN;
  localparam logic [7:0] StRunGo   = (8'b1 << ST_RUN) | (8'b1 << ST_GO);

  seq_state_t       state_q, state_d;
  logic             rr_q, rr_d, lock_q, lock_d, owner_q, owner_d;
  logic             go_pend_q, go_pend_d, rx_valid_q, rx_valid_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [7:0]       wdata_q, wdata_d, rx_data_q, rx_data_d;

  logic       op_start, op_wr, op_done, win, tx_want, go_ready;
  logic [1:0] op_addr;
  logic [7:0] op_wdata, op_rdata;

  // RESET gates the strobe so the bus idles while reset is held.
  uart_bus_master u_bus (
    .CLK   (CLK),
    .RESET (RESET),
    .start (op_start & ~RESET),
    .wr    (op_wr),
    .addr  (op_addr),
    .wdata (op_wdata),
    .done  (op_done),
    .rdata (op_rdata),
    .bus   (bus)
  );

  always_comb begin
    if (lock_q)          win = owner_q;
    else if (&req_valid) win = rr_q;
    else                 win = req_valid[1];
    tx_want  = (lock_q ? req_valid[owner_q] : |req_valid) && (count_q < CntMax) && !go_pend_q;
    go_ready = (count_q != '0) && (go_pend_q || count_q == CntMax);
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    go_pend_d  = go_pend_q;
    count_d    = count_q;
    poll_d     = poll_q;
    wdata_d    = wdata_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_ready ? 1'b0 : rx_valid_q;
    op_start   = 1'b0;
    op_wr      = 1'b1;
    op_addr    = REG_STATUS;
    op_wdata   = 8'h00;
    req_ready  = 2'b00;
    if (state_q == StIdle && poll_q != '0) poll_d = poll_q - PollW'(1);

    unique case (state_q)
      StInitStop: begin
        op_start = 1'b1;
        if (op_done) state_d = StInitBaud;
      end
      StInitBaud: begin
        op_start = 1'b1;
        op_addr  = REG_BAUD;
        op_wdata = BAUD_DIV;
        if (op_done) state_d = StInitRun;
      end
      StInitRun: begin
        op_start = 1'b1;
        op_wdata = StRunOnly;
        if (op_done) state_d = StInitMask;
      end
      StInitMask: begin
        op_start = 1'b1;
        op_addr  = REG_INT;
        op_wdata = INT_MASK;
        if (op_done) state_d = StIdle;
      end
      StIdle: begin
        // NINT is ignored while a byte is parked so GO traffic is not starved.
        if ((!bus.NINT && !rx_valid_q) || poll_q == '0) state_d = StRdStat;
        else if (go_ready)                              state_d = StWrGo;
        else if (tx_want)                               state_d = StRdStat;
      end
      StRdStat: begin
        op_start = 1'b1;
        op_wr    = 1'b0;
        if (op_done) begin
          poll_d = PollLoad;
          if (op_rdata[ST_RXRDY] && !rx_valid_q) begin
            state_d = StRdData;
          end else if (tx_want && !op_rdata[ST_TXFULL] && !op_rdata[ST_TXBUSY]) begin
            state_d = StGrant;
          end else begin
            // A stalled burst is flushed once a full poll interval passes with no bytes.
            if (poll_q == '0 && count_q != '0) go_pend_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRdData: begin
        op_start = 1'b1;
        op_wr    = 1'b0;
        op_addr  = REG_DATA;
        if (op_done) begin
          rx_data_d  = op_rdata;
          rx_valid_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StGrant: begin
        if (req_valid[win]) begin
          req_ready[win] = 1'b1;
          wdata_d = win ? req_data[15:8] : req_data[7:0];
          count_d = count_q + CntW'(1);
          lock_d  = 1'b1;
          owner_d = win;
          rr_d    = ~win;
          if (req_last[win]) go_pend_d = 1'b1;
          state_d = StWrData;
        end else begin
          state_d = StIdle;
        end
      end
      StWrData: begin
        op_start = 1'b1;
        op_addr  = REG_DATA;
        op_wdata = wdata_q;
        if (op_done) state_d = StIdle;
      end
      StWrGo: begin
        op_start = 1'b1;
        op_wdata = StRunGo;
        if (op_done) state_d = StWrRun;
      end
      StWrRun: begin
        op_start = 1'b1;
        op_wdata = StRunOnly;
        if (op_done) begin
          count_d   = '0;
          lock_d    = 1'b0;
          go_pend_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StInitStop;
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      go_pend_q  <= 1'b0;
      count_q    <= '0;
      poll_q     <= PollLoad;
      wdata_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      go_pend_q  <= go_pend_d;
      count_q    <= count_d;
      poll_q     <= poll_d;
      wdata_q    <= wdata_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Directed bench for uart_host_sequencer with a behavioural UART register model.
module tb_uart_host_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, busy;

  uart_host_sequencer_if bus_if ();

  uart_host_sequencer dut (
    .CLK       (clk),
    .RESET     (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  // UART model, evaluated mid-cycle while bus strobes are stable.
  logic [7:0] fifo[$];
  logic [7:0] txlog[$];
  logic [7:0] rxq[$];
  logic [9:0] wlog[$];
  int         go_sizes[$];
  int         txbusy_cnt = 0;
  int         wr_busy_viol = 0;
  int         bus_viol = 0;
  logic       run_r = 1'b0;
  logic [7:0] mask_r = 8'h00;
  logic [7:0] baud_r = 8'h00;
  logic [7:0] rd_byte = 8'h00;
  logic       nint_r = 1'b1;

  assign bus_if.DATA_IN = rd_byte;
  assign bus_if.NINT    = nint_r;

  always @(negedge clk) begin
    if (txbusy_cnt > 0) txbusy_cnt--;
    if (!bus_if.NCS && !bus_if.NW && !bus_if.NO) bus_viol++;
    if (!bus_if.NCS && !bus_if.NW) begin
      if (!bus_if.DATA_OE) bus_viol++;
      wlog.push_back({bus_if.ADDR, bus_if.DATA_OUT});
      case (bus_if.ADDR)
        2'd0: begin
          run_r = bus_if.DATA_OUT[0];
          if (!run_r) fifo.delete();
          if (bus_if.DATA_OUT[1] && run_r) begin
            go_sizes.push_back(fifo.size());
            while (fifo.size() > 0) txlog.push_back(fifo.pop_front());
            txbusy_cnt = 20;
          end
        end
        2'd1: mask_r = bus_if.DATA_OUT;
        2'd2: begin
          if (txbusy_cnt > 0) wr_busy_viol++;
          if (run_r && fifo.size() < 16) fifo.push_back(bus_if.DATA_OUT);
        end
        default: baud_r = bus_if.DATA_OUT;
      endcase
    end
    if (!bus_if.NCS && !bus_if.NO) begin
      if (bus_if.ADDR == 2'd0)
        rd_byte = {4'b0000, txbusy_cnt > 0, fifo.size() >= 16, rxq.size() > 0, run_r};
      else if (bus_if.ADDR == 2'd2)
        rd_byte = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
      else
        rd_byte = 8'h00;
    end
    nint_r = !(rxq.size() > 0 && mask_r[1]);
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives both requester queues until drained; called and returns at posedge+1.
  task automatic run_streams(input int budget);
    int cyc;
    logic [1:0] take;
    cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0) && cyc < budget) begin
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0);
      if (q0.size() > 0) {req_last[0], req_data[7:0]} = q0[0];
      if (q1.size() > 0) {req_last[1], req_data[15:8]} = q1[0];
      @(negedge clk);
      take = req_ready & req_valid;
      @(posedge clk);
      #1;
      if (take[0]) void'(q0.pop_front());
      if (take[1]) void'(q1.pop_front());
      cyc++;
    end
    req_valid = 2'b00;
    req_last  = 2'b00;
    check("streams_drained", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_go(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (go_sizes.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("go_count", go_sizes.size(), n);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int budget);
    int cyc;
    cyc = 0;
    while (!rx_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("rx_valid_seen", rx_valid, 1);
  endtask

  task automatic check_init(input string tag);
    check({tag, "_wcount"}, wlog.size(), 4);
    check({tag, "_stop"},   wlog[0], 10'h000);
    check({tag, "_baud"},   wlog[1], 10'h30C);
    check({tag, "_run"},    wlog[2], 10'h001);
    check({tag, "_mask"},   wlog[3], 10'h102);
  endtask

  initial begin
    int found;
    rst = 1'b1;
    req_valid = 2'b00;
    req_last  = 2'b00;
    req_data  = 16'h0000;
    rx_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ncs", bus_if.NCS, 1);
    check("rst_no", bus_if.NO, 1);
    check("rst_nw", bus_if.NW, 1);
    check("rst_addr", bus_if.ADDR, 0);
    check("rst_oe", bus_if.DATA_OE, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 1);

    // Init sequence: four writes, busy drops after the eighth edge
    @(posedge clk);
    #1;
    wlog.delete();
    rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("busy_at_7", busy, 1);
    @(negedge clk);
    check("busy_at_8", busy, 0);
    check_init("init");
    check("baud_reg", baud_r, 8'h0C);

    // Both requesters, 4-byte messages: req0 whole, GO, then req1
    @(posedge clk);
    #1;
    wlog.delete();
    txlog.delete();
    go_sizes.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({i == 3, 8'hB0 + 8'(i)});
      q1.push_back({i == 3, 8'hC0 + 8'(i)});
    end
    run_streams(400);
    wait_go(2, 400);
    check("rr_go0_size", go_sizes[0], 4);
    check("rr_go1_size", go_sizes[1], 4);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_tx%0d", i), txlog[i], (i < 4) ? 8'hB0 + 8'(i) : 8'hC0 + 8'(i - 4));

    // req0 A1,A2,A3(last): three data writes then st=03, st=01
    wlog.delete();
    txlog.delete();
    go_sizes.delete();
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b0, 8'hA2});
    q0.push_back({1'b1, 8'hA3});
    run_streams(300);
    wait_go(1, 300);
    check("msg_wcount", wlog.size(), 5);
    check("msg_w0", wlog[0], 10'h2A1);
    check("msg_w1", wlog[1], 10'h2A2);
    check("msg_w2", wlog[2], 10'h2A3);
    check("msg_go", wlog[3], 10'h003);
    check("msg_run", wlog[4], 10'h001);
    check("msg_txcount", txlog.size(), 3);
    check("msg_tx2", txlog[2], 8'hA3);

    // 20 bytes, no last: GO at 16, remaining 4 flushed by the poll timeout
    txlog.delete();
    go_sizes.delete();
    for (int i = 0; i < 20; i++) q0.push_back({1'b0, 8'h10 + 8'(i)});
    run_streams(1000);
    wait_go(2, 600);
    check("burst_go0_size", go_sizes[0], 16);
    check("burst_go1_size", go_sizes[1], 4);
    for (int i = 0; i < 20; i += 3)
      check($sformatf("burst_tx%0d", i), txlog[i], 8'h10 + 8'(i));
    check("burst_tx19", txlog[19], 8'h23);

    // RX: 0x5A held without rx_ready, 0x6B stays in the UART until accepted
    rxq.push_back(8'h5A);
    rxq.push_back(8'h6B);
    wait_rx(100);
    check("rx_first", rx_data, 8'h5A);
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("rx_hold_valid", rx_valid, 1);
    check("rx_hold_data", rx_data, 8'h5A);
    check("rx_second_kept", rxq.size(), 1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    wait_rx(100);
    check("rx_second", rx_data, 8'h6B);
    check("rx_drained", rxq.size(), 0);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    check("rx_cleared", rx_valid, 0);

    // RESET during a WR_DATA strobe: bus idles, init replays, queued TX flushed
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    req_data  = 16'h00E0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (!bus_if.NCS && !bus_if.NW && bus_if.ADDR == 2'd2) found = 1;
    end
    check("wr_data_seen", found, 1);
    #1;
    rst = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ncs", bus_if.NCS, 1);
    check("midrst_busy", busy, 1);
    @(posedge clk);
    #1;
    wlog.delete();
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("midrst_idle", busy, 0);
    check_init("replay");
    check("fifo_flushed", fifo.size(), 0);

    check("no_tx_write_while_busy", wr_busy_viol, 0);
    check("bus_strobe_rules", bus_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
